// File: rtl/alu_stream_if.sv
// Request/response bundle for alu_stream: operands and op in, result and flags out,
// each direction with its own valid/ready handshake.
interface alu_stream_if #(
    parameter int WIDTH = 8
);
    logic [2:0]       op_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic             out_carry;
    logic             out_zero;
    logic             out_err;

    modport master (
        output op_in, a_in, b_in, in_valid, out_ready,
        input  in_ready, out, out_valid, out_carry, out_zero, out_err
    );

    modport slave (
        input  op_in, a_in, b_in, in_valid, out_ready,
        output in_ready, out, out_valid, out_carry, out_zero, out_err
    );
endinterface

// File: rtl/alu_stream.sv
// Two-stage streaming ALU (request register S1, output register S2) with an iterative
// shift-add multiplier. Define ALU_STREAM_SAT_EN to saturate ADD/SUB/MUL instead of wrapping.
module alu_stream #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    alu_stream_if.slave  bus
);
    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam int         CW     = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

    logic               s1_valid_reg;
    logic [2:0]         s1_op_reg;
    logic [WIDTH-1:0]   s1_a_reg;
    logic [WIDTH-1:0]   s1_b_reg;

    mul_state_t         state_reg, state_next;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CW-1:0]      count_reg;

    logic [WIDTH-1:0]   out_reg;
    logic               out_valid_reg;
    logic               carry_reg;
    logic               zero_reg;
    logic               err_reg;

    logic               in_fire;
    logic               in_is_mul;
    logic               s1_is_mul;
    logic               compute_done;
    logic               advance;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   and_res, or_res, xor_res;
    logic [WIDTH-1:0]   res_raw;
    logic [WIDTH-1:0]   res_final;
    logic               carry_next;
    logic               err_next;

    assign in_is_mul    = (bus.op_in == OP_MUL) && (MUL_EN != 0);
    assign s1_is_mul    = (s1_op_reg == OP_MUL) && (MUL_EN != 0);
    assign compute_done = s1_valid_reg && (!s1_is_mul || (state_reg == DONE));
    assign advance      = compute_done && (!out_valid_reg || bus.out_ready);
    assign bus.in_ready = !s1_valid_reg || advance;
    assign in_fire      = bus.in_valid && bus.in_ready;

    // Request stage: a new request may enter in the same cycle the old one leaves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_op_reg    <= 3'd0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
        end else if (in_fire) begin
            s1_valid_reg <= 1'b1;
            s1_op_reg    <= bus.op_in;
            s1_a_reg     <= bus.a_in;
            s1_b_reg     <= bus.b_in;
        end else if (advance) begin
            s1_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The multiplier starts on acceptance so RUN begins in the first S1 cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (in_fire && in_is_mul) state_next = RUN;
            RUN:  if (count_reg == '0) state_next = DONE;
            DONE: if (advance) state_next = (in_fire && in_is_mul) ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
        end else if (in_fire && in_is_mul) begin
            acc_reg    <= '0;
            mcand_reg  <= {{WIDTH{1'b0}}, bus.a_in};
            mplier_reg <= bus.b_in;
            count_reg  <= CW'(WIDTH - 1);
        end else if (state_reg == RUN) begin
            if (mplier_reg[0]) begin
                acc_reg <= acc_reg + mcand_reg;
            end
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg - CW'(1);
        end
    end

    assign sum  = {1'b0, s1_a_reg} + {1'b0, s1_b_reg};
    assign diff = {1'b0, s1_a_reg} - {1'b0, s1_b_reg};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_logic
            assign and_res[gi] = s1_a_reg[gi] & s1_b_reg[gi];
            assign or_res[gi]  = s1_a_reg[gi] | s1_b_reg[gi];
            assign xor_res[gi] = s1_a_reg[gi] ^ s1_b_reg[gi];
        end
    endgenerate

    always_comb begin
        res_raw    = '0;
        carry_next = 1'b0;
        err_next   = 1'b0;
        case (s1_op_reg)
            OP_NOP: res_raw = '0;
            OP_ADD: begin
                res_raw    = sum[WIDTH-1:0];
                carry_next = sum[WIDTH];
            end
            OP_SUB: begin
                res_raw    = diff[WIDTH-1:0];
                carry_next = diff[WIDTH];
            end
            OP_AND: res_raw = and_res;
            OP_OR:  res_raw = or_res;
            OP_XOR: res_raw = xor_res;
            OP_MUL: begin
                if (MUL_EN != 0) begin
                    res_raw    = acc_reg[WIDTH-1:0];
                    carry_next = |acc_reg[2*WIDTH-1:WIDTH];
                end else begin
                    err_next = 1'b1;
                end
            end
            default: err_next = 1'b1;
        endcase
    end

`ifdef ALU_STREAM_SAT_EN
    // Only ADD/SUB/MUL ever raise carry, and only SUB clamps downwards.
    always_comb begin
        res_final = res_raw;
        if (carry_next) begin
            res_final = (s1_op_reg == OP_SUB) ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
        end
    end
`else
    assign res_final = res_raw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
            carry_reg     <= 1'b0;
            zero_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else if (advance) begin
            out_valid_reg <= 1'b1;
            out_reg       <= res_final;
            carry_reg     <= carry_next;
            zero_reg      <= (res_final == '0);
            err_reg       <= err_next;
        end else if (out_valid_reg && bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.out       = out_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_carry = carry_reg;
    assign bus.out_zero  = zero_reg;
    assign bus.out_err   = err_reg;
endmodule

// File: tb/tb_alu_stream.sv
// Scoreboard bench for alu_stream: directed corner cases plus randomized traffic with
// random output backpressure, checked against an arithmetic reference model.
module tb_alu_stream;
    localparam int W = 8;
    localparam logic [2:0] NOP = 3'd0, ADD = 3'd1, SUB = 3'd2, AND_ = 3'd3,
                           OR_ = 3'd4, XOR_ = 3'd5, MUL = 3'd6, RSV = 3'd7;

    typedef struct packed {
        logic         err;
        logic         zero;
        logic         carry;
        logic [W-1:0] res;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_stream_if #(.WIDTH(W)) bus();
    alu_stream #(.WIDTH(W), .MUL_EN(1)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    bit   force_en  = 1'b1;
    bit   force_val = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned m = 64'd1 << W;
        longint unsigned r = 0;
        longint unsigned p;
        exp_t e;
        e = '0;
        case (op)
            ADD: begin
                p = longint'(a) + longint'(b);
                e.carry = (p >= m);
                r = p % m;
            end
            SUB: begin
                e.carry = (a < b);
                r = (longint'(a) + m - longint'(b)) % m;
            end
            AND_: r = a & b;
            OR_:  r = a | b;
            XOR_: r = a ^ b;
            MUL: begin
                p = longint'(a) * longint'(b);
                e.carry = ((p / m) != 0);
                r = p % m;
            end
            RSV: e.err = 1'b1;
            default: r = 0;
        endcase
`ifdef ALU_STREAM_SAT_EN
        if (e.carry) r = (op == SUB) ? 0 : m - 1;
`endif
        e.res  = W'(r);
        e.zero = (r == 0);
        return e;
    endfunction

    // Output backpressure: forced level or random (ready about 3 cycles in 4).
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.out_ready = force_en ? force_val : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard on every output transfer and checks stalled outputs hold.
    initial begin
        bit   stalled = 1'b0;
        exp_t held;
        exp_t got;
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                stalled = 1'b0;
                continue;
            end
            got = {bus.out_err, bus.out_zero, bus.out_carry, bus.out};
            if (stalled) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_value", got, held);
            end
            if (bus.out_valid && bus.out_ready) begin
                stalled = 1'b0;
                n_out++;
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    $display("out %0d: res=%0d carry=%0b zero=%0b err=%0b (model res=%0d carry=%0b zero=%0b err=%0b)",
                             n_out, got.res, got.carry, got.zero, got.err, e.res, e.carry, e.zero, e.err);
                    chk("result", got, e);
                end
            end else if (bus.out_valid) begin
                stalled = 1'b1;
                held    = got;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int waited = 0;
        bit acc = 1'b0;
        @(negedge clk);
        bus.op_in    = op;
        bus.a_in     = a;
        bus.b_in     = b;
        bus.in_valid = 1'b1;
        while (!acc) begin
            #4;
            acc = bus.in_ready;
            if (acc) q.push_back(model(op, a, b));
            @(posedge clk);
            if (!acc) begin
                waited++;
                if (waited > 300) begin
                    chk("send_timeout", 0, 1);
                    break;
                end
                @(negedge clk);
            end
        end
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        force_en  = 1'b1;
        force_val = 1'b1;
        while (q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic lat_test(input string name, input logic [2:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input int exp_lat);
        int lat = -1;
        drain();
        send(op, a, b);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            #4;
            if (op == MUL && k <= W) chk("ready_low_run", bus.in_ready, 0);
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
        chk(name, lat, exp_lat);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.op_in    = 3'd0;
        bus.a_in     = '0;
        bus.b_in     = '0;

        #1 rst = 1'b1;
        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out", bus.out, 0);
        chk("rst_flags", {bus.out_carry, bus.out_zero, bus.out_err}, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #4 chk("ready_after_reset", bus.in_ready, 1);

        lat_test("add_latency", ADD, 8'd200, 8'd100, 2);
        lat_test("mul_latency", MUL, 8'd20, 8'd13, W + 2);

        send(SUB, 8'd5, 8'd7);
        send(SUB, 8'd7, 8'd7);
        send(RSV, 8'd9, 8'd3);
        send(NOP, 8'd9, 8'd3);
        send(AND_, 8'hF0, 8'h3C);
        send(OR_, 8'hF0, 8'h3C);
        send(XOR_, 8'hF0, 8'h3C);
        send(MUL, 8'd255, 8'd255);
        send(MUL, 8'd3, 8'd4);
        send(ADD, 8'd255, 8'd1);
        send(MUL, 8'd0, 8'd77);
        drain();

        // Back-to-back requests into a blocked output.
        force_val = 1'b0;
        fork
            begin
                send(ADD, 8'd1, 8'd1);
                send(ADD, 8'd2, 8'd2);
                send(ADD, 8'd3, 8'd3);
            end
            begin
                repeat (4) @(negedge clk);
                #4;
                chk("ready_low_full", bus.in_ready, 0);
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_out", bus.out, 2);
                force_val = 1'b1;
            end
        join
        drain();

        // Reset with a stalled result in S2 and a multiply running in S1.
        force_val = 1'b0;
        send(ADD, 8'd200, 8'd100);
        send(MUL, 8'd20, 8'd13);
        @(negedge clk);
        #2;
        chk("pre_rst_valid", bus.out_valid, 1);
        chk("pre_rst_ready_mul", bus.in_ready, 0);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", bus.out_valid, 0);
        chk("async_rst_out", bus.out, 0);
        chk("async_rst_flags", {bus.out_carry, bus.out_zero, bus.out_err}, 0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        force_val = 1'b1;
        #4 chk("ready_after_rst2", bus.in_ready, 1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            #4 chk("no_stale_output", bus.out_valid, 0);
        end

        // Random traffic with random backpressure.
        force_en = 1'b0;
        for (int i = 0; i < 300; i++) begin
            send(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_stream.md
ALU_STREAM -- requirements
Module: alu_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width (legal range 2..32).
REQ-002 SHALL have parameter MUL_EN, default 1; when 1, op MUL is supported, when 0, MUL is treated as an illegal op.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 op_in  input  3  operation: NOP=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, MUL=6; 7 reserved.
REQ-006 a_in, b_in  input  WIDTH each  unsigned operands.
REQ-007 in_valid  input  1  request valid; in_ready  output  1  block can accept.
REQ-008 out  output  WIDTH  result; out_valid  output  1  result valid; out_ready  input  1  consumer accepts.
REQ-009 out_carry  output  1  carry (ADD) / borrow (SUB) / high-half-nonzero (MUL), else 0.
REQ-010 out_zero  output  1  out == 0; out_err  output  1  op was reserved or illegal.

Function
REQ-011 Input transfer SHALL occur on a cycle with in_valid && in_ready; output transfer on out_valid && out_ready.
REQ-012 Two stages: S1 holds op/a/b/valid of the accepted request; S2 is the output register (out, flags, out_valid).
REQ-013 S1 advances into S2 when S1 valid, S1 compute done, and (!out_valid || out_ready).
REQ-014 in_ready SHALL be combinational: !S1_valid || S1 advancing this cycle.
REQ-015 Single-cycle ops: out_valid asserts exactly 2 cycles after input transfer when unstalled; full throughput of one result per cycle.
REQ-016 ADD: out = (a+b) mod 2^WIDTH, carry = bit WIDTH of the sum.
REQ-017 SUB: out = (a-b) mod 2^WIDTH, carry = 1 iff a < b.
REQ-018 AND/OR/XOR: bitwise; carry = 0.
REQ-019 NOP: out = 0, carry = 0, zero = 1, err = 0; still produces an output transfer.
REQ-020 Op 7, or MUL with MUL_EN=0: out = 0, carry = 0, zero = 1, err = 1.
REQ-021 MUL: iterative shift-add FSM, states IDLE -> RUN (WIDTH cycles, one multiplier bit per cycle) -> DONE -> IDLE on S1 advance.
REQ-022 MUL: out = low WIDTH bits of a*b, carry = 1 iff high WIDTH bits nonzero; out_valid exactly WIDTH+2 cycles after input transfer when unstalled.
REQ-023 While FSM is in RUN or DONE, in_ready = 0 unless S1 advances this cycle.
REQ-024 Stalled S2 (out_valid && !out_ready) SHALL hold out and all flags stable; S1 holds; no request is lost or duplicated.
REQ-025 Results SHALL leave in acceptance order.

Reset
REQ-026 rst asserted: S1 valid, out_valid, out, out_carry, out_zero, out_err SHALL clear to 0 immediately; FSM to IDLE.
REQ-027 Reset mid-MUL or with a stalled output discards the in-flight request; no output for it after reset release.
REQ-028 in_ready = 1 during the first cycle after reset release.

Configuration
REQ-029 Macro ALU_STREAM_SAT_EN defined: ADD results clamp to 2^WIDTH-1 on carry, SUB clamps to 0 on borrow, MUL clamps to 2^WIDTH-1 when high half nonzero; carry flags still report overflow.
REQ-030 Macro ALU_STREAM_SAT_EN undefined: wrap-around arithmetic per REQ-016/017/022; no saturation logic present.

Verification (WIDTH=8, MUL_EN=1, macro undefined unless noted)
REQ-031 ADD a=200 b=100, out_ready=1 -> 2 cycles later out=44, carry=1, zero=0; with SAT_EN out=255, carry=1.
REQ-032 SUB a=5 b=7 -> out=254, carry=1; SUB a=7 b=7 -> out=0, zero=1, carry=0; with SAT_EN a=5 b=7 -> out=0.
REQ-033 MUL a=20 b=13 -> out=4 (260 mod 256), carry=1, out_valid at cycle 10; in_ready=0 during RUN.
REQ-034 Back-to-back ADD 1+1, 2+2, 3+3 with out_ready=0 for 4 cycles then 1 -> outputs 2,4,6 in order, held stable, in_ready drops while both stages full.
REQ-035 op=7 -> out=0, err=1, zero=1; rst pulsed during MUL RUN -> all outputs 0 immediately, no stale result after release.
